tx_frame_sequencer: RTL and testbench
=====================================

TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

Interface
REQ-001 Parameter MIN_PAYLOAD, default 46, minimum payload bytes per frame, including pad, covered by the FCS.
REQ-002 Parameter IFG_BYTES, default 12, idle cycles enforced after each frame or abort.
REQ-003 Parameter CRC_TIMEOUT, default 4, maximum CRC_WAIT cycles before abort.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 tx_start  in  1  one-cycle frame request; sampled only in IDLE.
REQ-008 tx_data  in  8  payload byte from client.
REQ-009 tx_valid  in  1  tx_data valid.
REQ-010 tx_last  in  1  qualifies the final payload byte.
REQ-011 tx_ready  out  1  byte accepted when tx_valid && tx_ready; combinational, high only in PAYLOAD.
REQ-012 mac_data  out  8  registered byte stream to PHY side.
REQ-013 mac_valid  out  1  registered; mac_data valid.
REQ-014 crc_data  out  8  byte to CRC unit (data_in).
REQ-015 crc_valid  out  1  to CRC unit data_valid.
REQ-016 crc_en  out  1  to CRC unit crc_en; frame-accumulate window.
REQ-017 crc_in  in  32  CRC unit crc_out.
REQ-018 crc_done_in  in  1  CRC unit crc_done pulse.
REQ-019 tx_busy  out  1  high in every state except IDLE.
REQ-020 tx_done  out  1  one-cycle pulse after the last FCS byte.
REQ-021 tx_error  out  1  one-cycle pulse on underrun or CRC timeout.

Function
REQ-022 States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, CRC_WAIT, FCS, IFG.
REQ-023 IDLE + tx_start -> PREAMBLE; mac_valid=1 with 0x55 from the next cycle for exactly 7 cycles, then SFD emits 0xD5 for 1 cycle, then PAYLOAD.
REQ-024 PAYLOAD: each accepted byte appears on mac_data and crc_data one cycle later with mac_valid=crc_valid=crc_en=1; an 11-bit byte counter increments and saturates at 2047.
REQ-025 In PAYLOAD, tx_valid=0 is an underrun: pulse tx_error, drop crc_en and mac_valid next cycle, go to IFG; the resulting crc_done_in is ignored.
REQ-026 tx_last accepted with count+1 < MIN_PAYLOAD -> PAD; otherwise -> CRC_WAIT.
REQ-027 PAD emits 0x00 on mac_data/crc_data with crc_en=1 until the counter equals MIN_PAYLOAD, then -> CRC_WAIT.
REQ-028 CRC_WAIT: crc_en=0, mac_valid=0; on crc_done_in latch crc_in and -> FCS; no crc_done_in within CRC_TIMEOUT cycles -> tx_error pulse, IFG.
REQ-029 FCS emits 4 bytes on consecutive cycles: crc[7:0], [15:8], [23:16], [31:24]; crc_valid=0 throughout.
REQ-030 After the 4th FCS byte, pulse tx_done and enter IFG; IFG holds mac_valid=0 for IFG_BYTES cycles, then IDLE.
REQ-031 tx_start outside IDLE is ignored; tx_start in the final IFG cycle is ignored.
REQ-032 crc_en=1 only for cycles carrying a payload or pad byte, contiguous within a frame.

Reset
REQ-033 rst takes effect at the next edge from any state: IDLE; mac_valid, crc_valid, crc_en, tx_busy, tx_done, tx_error = 0; mac_data, crc_data = 0x00; counters and latched CRC = 0.
REQ-034 Reset mid-frame produces no tx_done or tx_error pulse.

Configuration
REQ-035 Macro TX_PAD_EN: defined -> PAD state and MIN_PAYLOAD padding as above; undefined -> no PAD state, tx_last always -> CRC_WAIT, short frames sent unpadded, MIN_PAYLOAD unused.

Verification
REQ-036 60-byte payload 0x00..0x3B, tx_start at cycle 0 -> 7x0x55, 0xD5, 60 bytes, FCS = 4 bytes of latched crc_in LSB first, tx_done once, 12 idle cycles.
REQ-037 10-byte payload with TX_PAD_EN -> 36 pad bytes 0x00 with crc_en=1, 46 crc_valid cycles total; without the macro -> 10 crc_valid cycles, no pad.
REQ-038 tx_valid dropped after byte 5 -> tx_error one cycle, mac_valid low next cycle, no FCS, IDLE after 12 cycles.
REQ-039 crc_done_in held 0 in CRC_WAIT -> tx_error after 4 cycles, no FCS bytes, no tx_done.
REQ-040 rst asserted mid-PAYLOAD, tx_start re-pulsed during IFG -> outputs at reset values next edge; the re-pulse is ignored.

Source files
------------

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: builds an Ethernet-style transmit frame around a client
// payload stream: preamble, SFD, payload, optional pad, externally computed FCS
// and an enforced inter-frame gap.
// The payload bytes and the pad bytes are forwarded to an external CRC unit.
// The FCS that this unit returns is latched and sent LSB first.
// Build option: define TX_PAD_EN to pad short frames up to MIN_PAYLOAD bytes.
// Without TX_PAD_EN, short frames go straight to the FCS unpadded.
// Output timing: every output except tx_ready is registered. An accepted
// payload byte therefore appears on the outputs one cycle after acceptance.
// The first PAYLOAD cycle carries no byte because nothing has been accepted yet.

module tx_frame_sequencer #(
    parameter int MIN_PAYLOAD = 46,
    parameter int IFG_BYTES   = 12,
    parameter int CRC_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  mac_data,
    output logic        mac_valid,
    output logic [7:0]  crc_data,
    output logic        crc_valid,
    output logic        crc_en,
    input  logic [31:0] crc_in,
    input  logic        crc_done_in,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_error
);

    localparam logic [2:0] IDLE_ST     = 3'd0;
    localparam logic [2:0] PREAMBLE_ST = 3'd1;
    localparam logic [2:0] SFD_ST      = 3'd2;
    localparam logic [2:0] PAYLOAD_ST  = 3'd3;
`ifdef TX_PAD_EN
    localparam logic [2:0] PAD_ST      = 3'd4;
    localparam logic [11:0] MIN_C      = 12'(MIN_PAYLOAD);
`endif
    localparam logic [2:0] CRC_WAIT_ST = 3'd5;
    localparam logic [2:0] FCS_ST      = 3'd6;
    localparam logic [2:0] IFG_ST      = 3'd7;

    localparam logic [15:0] PRE_LAST_C  = 16'd6;
    localparam logic [15:0] FCS_LAST_C  = 16'd3;
    localparam logic [15:0] WAIT_LAST_C = 16'(CRC_TIMEOUT - 1);
    localparam logic [15:0] IFG_LAST_C  = 16'(IFG_BYTES - 1);
    localparam logic [10:0] CNT_MAX_C   = 11'h7FF;

    localparam logic [7:0] PREAMBLE_BYTE_C = 8'h55;
    localparam logic [7:0] SFD_BYTE_C      = 8'hD5;

    // Byte counter increment that sticks at its maximum value.
    function automatic logic [10:0] sat_inc(input logic [10:0] cnt);
        logic [10:0] res;
        if (cnt == CNT_MAX_C) begin
            res = cnt;
        end else begin
            res = cnt + 11'd1;
        end
        return res;
    endfunction

    // Selects an FCS byte: index 0 is the least significant byte.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [7:0] res;
        case (idx)
            2'd0:    res = crc[7:0];
            2'd1:    res = crc[15:8];
            2'd2:    res = crc[23:16];
            2'd3:    res = crc[31:24];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    logic [2:0]  state_r, state_s;
    logic [15:0] step_r, step_s;
    logic [10:0] byte_cnt_r, byte_cnt_s, byte_inc_s;
    logic [31:0] crc_r, crc_s;
    logic [7:0]  mac_data_r, mac_data_s;
    logic        mac_valid_r, mac_valid_s;
    logic [7:0]  crc_data_r, crc_data_s;
    logic        crc_valid_r, crc_valid_s;
    logic        crc_en_r, crc_en_s;
    logic        tx_busy_r;
    logic        tx_done_r, tx_done_s;
    logic        tx_error_r, tx_error_s;

    assign tx_ready  = (state_r == PAYLOAD_ST);
    assign mac_data  = mac_data_r;
    assign mac_valid = mac_valid_r;
    assign crc_data  = crc_data_r;
    assign crc_valid = crc_valid_r;
    assign crc_en    = crc_en_r;
    assign tx_busy   = tx_busy_r;
    assign tx_done   = tx_done_r;
    assign tx_error  = tx_error_r;

    // Next-state and next-output decode; the outputs are what the next edge loads.
    always_comb begin
        state_s     = state_r;
        step_s      = step_r;
        byte_cnt_s  = byte_cnt_r;
        byte_inc_s  = sat_inc(byte_cnt_r);
        crc_s       = crc_r;
        mac_data_s  = 8'h00;
        mac_valid_s = 1'b0;
        crc_data_s  = 8'h00;
        crc_valid_s = 1'b0;
        crc_en_s    = 1'b0;
        tx_done_s   = 1'b0;
        tx_error_s  = 1'b0;

        case (state_r)
            IDLE_ST: begin
                if (tx_start) begin
                    state_s     = PREAMBLE_ST;
                    step_s      = 16'd0;
                    byte_cnt_s  = 11'd0;
                    mac_data_s  = PREAMBLE_BYTE_C;
                    mac_valid_s = 1'b1;
                end else begin
                    state_s = IDLE_ST;
                end
            end
            PREAMBLE_ST: begin
                mac_valid_s = 1'b1;
                if (step_r == PRE_LAST_C) begin
                    state_s    = SFD_ST;
                    step_s     = 16'd0;
                    mac_data_s = SFD_BYTE_C;
                end else begin
                    step_s     = step_r + 16'd1;
                    mac_data_s = PREAMBLE_BYTE_C;
                end
            end
            SFD_ST: begin
                state_s = PAYLOAD_ST;
                step_s  = 16'd0;
            end
            PAYLOAD_ST: begin
                if (tx_valid) begin
                    mac_data_s  = tx_data;
                    mac_valid_s = 1'b1;
                    crc_data_s  = tx_data;
                    crc_valid_s = 1'b1;
                    crc_en_s    = 1'b1;
                    byte_cnt_s  = byte_inc_s;
                    if (tx_last) begin
                        step_s = 16'd0;
`ifdef TX_PAD_EN
                        if ({1'b0, byte_inc_s} < MIN_C) begin
                            state_s = PAD_ST;
                        end else begin
                            state_s = CRC_WAIT_ST;
                        end
`else
                        state_s = CRC_WAIT_ST;
`endif
                    end else begin
                        state_s = PAYLOAD_ST;
                    end
                end else begin
                    // Underrun: the frame is abandoned and no FCS is sent.
                    tx_error_s = 1'b1;
                    state_s    = IFG_ST;
                    step_s     = 16'd0;
                end
            end
`ifdef TX_PAD_EN
            PAD_ST: begin
                mac_valid_s = 1'b1;
                crc_valid_s = 1'b1;
                crc_en_s    = 1'b1;
                byte_cnt_s  = byte_inc_s;
                if ({1'b0, byte_inc_s} >= MIN_C) begin
                    state_s = CRC_WAIT_ST;
                    step_s  = 16'd0;
                end else begin
                    state_s = PAD_ST;
                end
            end
`endif
            CRC_WAIT_ST: begin
                if (crc_done_in) begin
                    crc_s       = crc_in;
                    mac_data_s  = crc_in[7:0];
                    mac_valid_s = 1'b1;
                    state_s     = FCS_ST;
                    step_s      = 16'd0;
                end else if (step_r == WAIT_LAST_C) begin
                    tx_error_s = 1'b1;
                    state_s    = IFG_ST;
                    step_s     = 16'd0;
                end else begin
                    step_s = step_r + 16'd1;
                end
            end
            FCS_ST: begin
                if (step_r == FCS_LAST_C) begin
                    tx_done_s = 1'b1;
                    state_s   = IFG_ST;
                    step_s    = 16'd0;
                end else begin
                    mac_data_s  = fcs_byte(crc_r, step_r[1:0] + 2'd1);
                    mac_valid_s = 1'b1;
                    step_s      = step_r + 16'd1;
                end
            end
            IFG_ST: begin
                if (step_r == IFG_LAST_C) begin
                    state_s = IDLE_ST;
                    step_s  = 16'd0;
                end else begin
                    step_s = step_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE_ST;
                step_s  = 16'd0;
            end
        endcase
    end

    // State, counters, latched FCS and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE_ST;
            step_r      <= 16'd0;
            byte_cnt_r  <= 11'd0;
            crc_r       <= 32'd0;
            mac_data_r  <= 8'h00;
            mac_valid_r <= 1'b0;
            crc_data_r  <= 8'h00;
            crc_valid_r <= 1'b0;
            crc_en_r    <= 1'b0;
            tx_busy_r   <= 1'b0;
            tx_done_r   <= 1'b0;
            tx_error_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            step_r      <= step_s;
            byte_cnt_r  <= byte_cnt_s;
            crc_r       <= crc_s;
            mac_data_r  <= mac_data_s;
            mac_valid_r <= mac_valid_s;
            crc_data_r  <= crc_data_s;
            crc_valid_r <= crc_valid_s;
            crc_en_r    <= crc_en_s;
            tx_busy_r   <= (state_s != IDLE_ST);
            tx_done_r   <= tx_done_s;
            tx_error_r  <= tx_error_s;
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed testbench for tx_frame_sequencer. It covers reset, a full frame,
// short-frame padding (depends on TX_PAD_EN), underrun, CRC timeout,
// mid-frame reset and tx_start pulses during the inter-frame gap.

module tb_tx_frame_sequencer;

    logic        clk;
    logic        rst;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [7:0]  mac_data;
    logic        mac_valid;
    logic [7:0]  crc_data;
    logic        crc_valid;
    logic        crc_en;
    logic [31:0] crc_in;
    logic        crc_done_in;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mac_q[$];
    logic [7:0] crc_q[$];
    logic [7:0] exp_q[$];
    int en_cnt, en_rise, done_cnt, err_cnt, idle_run, ifg_valid;
    int first_valid, last_valid, err_cyc, timed_out;
    logic err_mac_valid;

    tx_frame_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .mac_data    (mac_data),
        .mac_valid   (mac_valid),
        .crc_data    (crc_data),
        .crc_valid   (crc_valid),
        .crc_en      (crc_en),
        .crc_in      (crc_in),
        .crc_done_in (crc_done_in),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame and records what the DUT emits.
    // underrun_at: number of bytes to send before tx_valid is dropped (-1 means never).
    // done_delay: cycles after crc_en falls before crc_done_in is pulsed (-1 means never).
    task automatic run_frame(input int nbytes, input int underrun_at, input int done_delay,
                             input logic [31:0] crc_val, input bit ifg_pulse);
        int sent, since_fall, cyc;
        bit seen_en, prev_en, pulse_seen;
        mac_q.delete();
        crc_q.delete();
        en_cnt = 0; en_rise = 0; done_cnt = 0; err_cnt = 0; idle_run = 0; ifg_valid = 0;
        first_valid = -1; last_valid = -1; err_cyc = -1; timed_out = 1; err_mac_valid = 1'b1;
        sent = 0; since_fall = 0; cyc = 0; seen_en = 1'b0; prev_en = 1'b0; pulse_seen = 1'b0;
        crc_in = crc_val;
        tx_start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            tick();
            cyc++;
            tx_start    = 1'b0;
            crc_done_in = 1'b0;
            if (mac_valid) begin
                mac_q.push_back(mac_data);
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
            end
            if (crc_valid) crc_q.push_back(crc_data);
            if (crc_en) en_cnt++;
            if (crc_en && !prev_en) en_rise++;
            prev_en = crc_en;
            if (tx_done) begin
                done_cnt++;
                pulse_seen = 1'b1;
            end
            if (tx_error) begin
                err_cnt++;
                pulse_seen = 1'b1;
                err_cyc = cyc;
                err_mac_valid = mac_valid;
            end
            if (pulse_seen && tx_busy) begin
                idle_run++;
                if (mac_valid) ifg_valid++;
            end
            if (!tx_busy) begin
                timed_out = 0;
                break;
            end
            if (crc_en) seen_en = 1'b1;
            if (seen_en && !crc_en) since_fall++;
            if (done_delay >= 0 && since_fall == done_delay + 1) crc_done_in = 1'b1;
            if (done_delay >= 0 && since_fall == done_delay + 2) crc_in = ~crc_val;
            if (ifg_pulse && pulse_seen && (idle_run == 5 || idle_run == 12)) tx_start = 1'b1;
            if (tx_ready && sent != underrun_at && sent < nbytes) begin
                tx_valid = 1'b1;
                tx_data  = sent[7:0];
                tx_last  = (sent == nbytes - 1);
                sent++;
            end else begin
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_start = 1'b0;
        crc_done_in = 1'b0;
        check("frame_terminates", timed_out, 0);
    endtask

    initial begin
        int bad, zeros, sent, act;
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
        crc_in = 32'd0; crc_done_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check("reset_busy", tx_busy, 0);
        check("reset_ready", tx_ready, 0);
        check("reset_outputs", {mac_data, mac_valid, crc_data, crc_valid, crc_en, tx_done, tx_error}, 0);

        // 60-byte frame, CRC returned immediately after crc_en falls.
        run_frame(60, -1, 0, 32'hA1B2C3D4, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 60; i++) exp_q.push_back(i[7:0]);
        exp_q.push_back(8'hD4); exp_q.push_back(8'hC3); exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
        check("f60_len", mac_q.size(), 72);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < mac_q.size(); i++)
            if (mac_q[i] !== exp_q[i] && bad < 0) bad = i;
        check("f60_stream_first_bad_idx", bad, -1);
        check("f60_first_valid_cycle", first_valid, 1);
        check("f60_crc_valid_cnt", crc_q.size(), 60);
        bad = -1;
        for (int i = 0; i < crc_q.size(); i++)
            if (crc_q[i] !== i[7:0] && bad < 0) bad = i;
        check("f60_crc_data_first_bad_idx", bad, -1);
        check("f60_crc_en_cnt", en_cnt, 60);
        check("f60_crc_en_runs", en_rise, 1);
        check("f60_done_cnt", done_cnt, 1);
        check("f60_err_cnt", err_cnt, 0);
        check("f60_ifg_len", idle_run, 12);
        check("f60_ifg_valid", ifg_valid, 0);

        // 10-byte short frame.
        run_frame(10, -1, 1, 32'h12345678, 1'b0);
`ifdef TX_PAD_EN
        check("f10_crc_valid_cnt", crc_q.size(), 46);
        check("f10_crc_en_cnt", en_cnt, 46);
        check("f10_len", mac_q.size(), 58);
        zeros = 0;
        for (int i = 10; i < crc_q.size(); i++) if (crc_q[i] === 8'h00) zeros++;
        check("f10_pad_zero_cnt", zeros, 36);
`else
        check("f10_crc_valid_cnt", crc_q.size(), 10);
        check("f10_crc_en_cnt", en_cnt, 10);
        check("f10_len", mac_q.size(), 22);
`endif
        check("f10_crc_en_runs", en_rise, 1);
        check("f10_fcs_byte3", mac_q[mac_q.size() - 1], 8'h12);
        check("f10_fcs_byte0", mac_q[mac_q.size() - 4], 8'h78);
        check("f10_done_cnt", done_cnt, 1);

        // Underrun after 5 bytes; the later crc_done_in must be ignored.
        run_frame(20, 5, 0, 32'hDEADBEEF, 1'b0);
        check("ur_err_cnt", err_cnt, 1);
        check("ur_done_cnt", done_cnt, 0);
        check("ur_len", mac_q.size(), 13);
        check("ur_mac_valid_at_err", err_mac_valid, 0);
        check("ur_err_after_last", err_cyc - last_valid, 1);
        check("ur_ifg_len", idle_run, 12);

        // CRC timeout: crc_done_in never arrives.
        run_frame(50, -1, -1, 32'h0BADF00D, 1'b0);
        check("to_err_cnt", err_cnt, 1);
        check("to_done_cnt", done_cnt, 0);
        check("to_len", mac_q.size(), 58);
        check("to_err_latency", err_cyc - last_valid, 4);
        check("to_ifg_len", idle_run, 12);

        // tx_start pulsed mid-gap and in the final gap cycle must not start a frame.
        run_frame(50, -1, 0, 32'h11223344, 1'b1);
        check("ifg_done_cnt", done_cnt, 1);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_busy || mac_valid) act++;
        end
        check("ifg_restart_ignored", act, 0);

        // Reset while in the middle of the payload.
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        sent = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tx_ready && sent < 10) begin
                tx_valid = 1'b1;
                tx_data  = sent[7:0];
                sent++;
            end else if (sent == 10) begin
                break;
            end else begin
                tx_valid = 1'b0;
            end
        end
        check("mr_busy_before", tx_busy, 1);
        check("mr_ready_before", tx_ready, 1);
        rst = 1'b1;
        tick();
        check("mr_busy_after", tx_busy, 0);
        check("mr_ready_after", tx_ready, 0);
        check("mr_outputs_after", {mac_data, mac_valid, crc_data, crc_valid, crc_en, tx_done, tx_error}, 0);
        rst = 1'b0;
        tx_valid = 1'b0;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tx_done || tx_error || tx_busy || mac_valid) act++;
        end
        check("mr_quiet_after", act, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
